// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the boot loader.
// The loader takes the slave side; the byte source and memory observer take the master side.
interface prog_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program memory writer: parses count header, little-endian words and XOR checksum,
// writes words from address 0 and releases the core only after a verified image.
module prog_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    prog_loader_if.slave        bus,
    output logic                core_hold,
    output logic                done,
    output logic                err
);
    typedef enum logic [2:0] {
        StIdle,
        StCntLo,
        StCntHi,
        StData,
        StCheck,
        StDone,
        StError
    } state_e;

    localparam logic [16:0] MaxCount = 17'(MEM_DEPTH);

    state_e                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           shift_q, shift_d;
    logic [7:0]            csum_q, csum_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  core_hold_q, core_hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  accept;

    // in_ready_q mirrors the byte-consuming states, so it alone qualifies acceptance.
    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d    = StCntLo;
                    count_d    = '0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    shift_d    = '0;
                    csum_d     = '0;
                end
            end
            StCntLo: begin
                if (accept) begin
                    count_d[7:0] = bus.in_data;
                    csum_d       = csum_q ^ bus.in_data;
                    state_d      = StCntHi;
                end
            end
            StCntHi: begin
                if (accept) begin
                    count_d[15:8] = bus.in_data;
                    csum_d        = csum_q ^ bus.in_data;
                    if (count_d == 16'd0) begin
                        state_d = StCheck;
                    end else if ({1'b0, count_d} > MaxCount) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d     = csum_q ^ bus.in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    shift_d    = {bus.in_data, shift_q[23:8]};
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = DATA_WIDTH'({bus.in_data, shift_q});
                        word_idx_d  = word_idx_q + 16'd1;
                        if (word_idx_d == count_q) begin
                            state_d = StCheck;
                        end
                    end
                end
            end
            StCheck: begin
                if (accept) begin
                    state_d = (bus.in_data == csum_q) ? StDone : StError;
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d  = (state_d == StCntLo) || (state_d == StCntHi) ||
                      (state_d == StData)  || (state_d == StCheck);
        core_hold_d = (state_d != StDone);
        done_d      = (state_d == StDone);
        err_d       = (state_d == StError);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            shift_q     <= '0;
            csum_q      <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            csum_q      <= csum_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_hold_q <= core_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign core_hold     = core_hold_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized image loads checked against a byte-level model of the image format.
module tb_prog_loader;
    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic core_hold;
    logic done;
    logic err;

    prog_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    prog_loader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .core_hold(core_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    logic          exp_done;
    logic          exp_err;
    int            exp_len;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            got_addr.push_back(bus.mem_addr);
            got_data.push_back(bus.mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Image semantics: count, count*4 LE word bytes, XOR of all preceding bytes.
    task automatic model(input logic [7:0] bs[$]);
        int unsigned cnt;
        logic [7:0]  x;
        exp_addr.delete();
        exp_data.delete();
        cnt = int'(bs[0]) + 256 * int'(bs[1]);
        if (cnt > DEPTH) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
            exp_len  = 2;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * int'(cnt); i++) x = x ^ bs[i];
        for (int w = 0; w < int'(cnt); w++) begin
            exp_addr.push_back(AW'(w));
            exp_data.push_back({bs[2+4*w+3], bs[2+4*w+2], bs[2+4*w+1], bs[2+4*w]});
        end
        exp_len  = 3 + 4 * int'(cnt);
        exp_done = (bs[exp_len-1] == x);
        exp_err  = !exp_done;
    endtask

    task automatic make_image(input int n, input bit bad, output logic [7:0] bs[$]);
        logic [7:0]  x;
        logic [15:0] n16;
        logic [31:0] w;
        n16 = 16'(n);
        bs = {};
        bs.push_back(n16[7:0]);
        bs.push_back(n16[15:8]);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            bs.push_back(w[7:0]);
            bs.push_back(w[15:8]);
            bs.push_back(w[23:16]);
            bs.push_back(w[31:24]);
        end
        x = 8'h00;
        foreach (bs[i]) x = x ^ bs[i];
        bs.push_back(bad ? (x ^ 8'h01) : x);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] bs[$], input int gap_pct, input int start_at);
        int w;
        model(bs);
        got_addr.delete();
        got_data.delete();
        for (int i = 0; i < exp_len; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            check("in_ready_busy", bus.in_ready, 1'b1);
            bus.in_valid = 1'b1;
            bus.in_data  = bs[i];
            start        = (i == start_at);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            start        = 1'b0;
            if (i >= 2 && i < exp_len - 1 && ((i - 2) % 4) == 3) begin
                w = (i - 2) / 4;
                check("we_latency", bus.mem_we, 1'b1);
                check("we_addr", bus.mem_addr, exp_addr[w]);
                check("we_data", bus.mem_wdata, exp_data[w]);
            end
        end
        check("done_edge", done, exp_done);
        check("err_edge", err, exp_err);
        check("hold_edge", core_hold, !exp_done);
        @(negedge clk);
        @(negedge clk);
        check("in_ready_end", bus.in_ready, 1'b0);
        check("n_writes", got_addr.size(), exp_addr.size());
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
            check("wr_addr", got_addr[k], exp_addr[k]);
            check("wr_data", got_data[k], exp_data[k]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1'b0);
        check({tag, "_mem_we"}, bus.mem_we, 1'b0);
        check({tag, "_mem_addr"}, bus.mem_addr, '0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, '0);
        check({tag, "_core_hold"}, core_hold, 1'b1);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        logic [7:0] nom[$];
        logic [7:0] bad[$];
        logic [7:0] img[$];

        nom = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
        bad = nom;
        bad[10] = 8'h29;

        rst          = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Nominal back-to-back load
        pulse_start();
        send(nom, 0, -1);

        // Start in DONE clears done and re-arms
        pulse_start();
        check("restart_done", done, 1'b0);
        check("restart_hold", core_hold, 1'b1);
        check("restart_ready", bus.in_ready, 1'b1);
        send(bad, 0, -1);

        // Oversize header, then full-depth image
        pulse_start();
        img = '{8'h01, 8'h04};
        send(img, 0, -1);
        pulse_start();
        make_image(DEPTH, 1'b0, img);
        send(img, 0, -1);
        if (got_addr.size() > 0) check("last_addr", got_addr[got_addr.size()-1], 10'h3FF);

        // Empty image and backpressure
        pulse_start();
        img = '{8'h00, 8'h00, 8'h00};
        send(img, 0, -1);
        pulse_start();
        send(nom, 50, -1);

        // Start during DATA is ignored
        pulse_start();
        send(nom, 0, 4);

        // Reset mid-load after five data bytes
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = nom[i];
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        send(nom, 0, -1);

        // Random images, some with corrupted checksum
        for (int k = 0; k < 8; k++) begin
            pulse_start();
            make_image(int'($urandom_range(0, 6)), ($urandom_range(3) == 0), img);
            send(img, 30, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
